// File: rtl/reg_file_pkg.sv
// Shared constants and types for the parametrised register file.
// DEPTH is always derived from an address width through depth_of().
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);

endpackage

// File: rtl/reg_file_wr_decoder.sv
// Enable-gated one-hot write decoder: ADDR_W address bits to 2^ADDR_W selects.
module wr_decoder #(
    parameter int ADDR_W = reg_file_pkg::ADDR_W_DEF
) (
    input  logic                          i_en,
    input  logic [ADDR_W-1:0]             i_addr,
    output logic [(1 << ADDR_W)-1:0]      o_sel
);

    always_comb begin
        o_sel = '0;
        if (i_en) begin
            o_sel[i_addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_param.sv
// Register file with two combinational read ports, optional write bypass,
// optional hardwired-zero entry 0 and a one-entry-per-cycle bulk-clear sweep.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              writeEn,
    input  logic [ADDR_W-1:0] RegNum,
    input  logic [DATA_W-1:0] RegData,
    input  logic [ADDR_W-1:0] rdNumA,
    output logic [DATA_W-1:0] rdDataA,
    input  logic [ADDR_W-1:0] rdNumB,
    output logic [DATA_W-1:0] rdDataB,
    input  logic              clearReq,
    output logic              busy,
    output clr_state_t        dbg_state
);

    localparam int DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_busy;
    logic              w_wr_en;
    logic [DEPTH-1:0]  w_dec_sel;
    logic [DEPTH-1:0]  w_wr_sel;
    logic              w_byp_ok;

    assign w_busy    = (r_state == CLEAR);
    assign w_wr_en   = writeEn && !w_busy;
    assign busy      = w_busy;
    assign dbg_state = r_state;

    wr_decoder #(
        .ADDR_W (ADDR_W)
    ) u_wr_decoder (
        .i_en   (w_wr_en),
        .i_addr (RegNum),
        .o_sel  (w_dec_sel)
    );

    always_comb begin
        w_wr_sel = w_dec_sel;
        if (ZERO_REG != 0) begin
            w_wr_sel[0] = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (clearReq) begin
                    w_state_nxt = CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                w_ptr_nxt = r_ptr + ADDR_W'(1);
                if (r_ptr == LAST_IDX) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Writes are already masked off while busy, so the sweep never races a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_sel[i]) begin
                    r_mem[i] <= RegData;
                end
            end
            if (w_busy) begin
                r_mem[r_ptr] <= '0;
            end
        end
    end

    // Bypass source is valid only for a write that will actually land.
    assign w_byp_ok = (BYPASS != 0) && w_wr_en && !((ZERO_REG != 0) && (RegNum == '0));

    always_comb begin
        rdDataA = r_mem[rdNumA];
        if (w_byp_ok && (rdNumA == RegNum)) begin
            rdDataA = RegData;
        end
        if ((ZERO_REG != 0) && (rdNumA == '0)) begin
            rdDataA = '0;
        end
    end

    always_comb begin
        rdDataB = r_mem[rdNumB];
        if (w_byp_ok && (rdNumB == RegNum)) begin
            rdDataB = RegData;
        end
        if ((ZERO_REG != 0) && (rdNumB == '0)) begin
            rdDataB = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: one instance with zero-reg and bypass on, one with both off,
// compared every step against an array-based reference of the register file.
module tb_reg_file_param;
    import reg_file_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          writeEn;
    logic          clearReq;
    logic [AW-1:0] RegNum;
    logic [AW-1:0] rdNumA;
    logic [AW-1:0] rdNumB;
    logic [DW-1:0] RegData;

    logic [DW-1:0] rd_a1, rd_b1, rd_a0, rd_b0;
    logic          busy1, busy0;
    clr_state_t    st1, st0;

    logic [DW-1:0] m1 [D];
    logic [DW-1:0] m0 [D];
    int            busy_left;
    int            n_err = 0;
    int            n_chk = 0;

    always #5 clk = ~clk;

    reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .writeEn(writeEn), .RegNum(RegNum), .RegData(RegData),
        .rdNumA(rdNumA), .rdDataA(rd_a1), .rdNumB(rdNumB), .rdDataB(rd_b1),
        .clearReq(clearReq), .busy(busy1), .dbg_state(st1)
    );

    reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .writeEn(writeEn), .RegNum(RegNum), .RegData(RegData),
        .rdNumA(rdNumA), .rdDataA(rd_a0), .rdNumB(rdNumB), .rdDataB(rd_b0),
        .clearReq(clearReq), .busy(busy0), .dbg_state(st0)
    );

    function automatic logic [DW-1:0] exp_rd(input bit v1, input logic [AW-1:0] a);
        if (v1 && a == '0) return '0;
        if (v1 && writeEn && busy_left == 0 && a == RegNum) return RegData;
        return v1 ? m1[a] : m0[a];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0] eb;
        eb = (busy_left > 0) ? 32'd1 : 32'd0;
        chk({tag, ":a1"}, rd_a1, exp_rd(1'b1, rdNumA));
        chk({tag, ":b1"}, rd_b1, exp_rd(1'b1, rdNumB));
        chk({tag, ":a0"}, rd_a0, exp_rd(1'b0, rdNumA));
        chk({tag, ":b0"}, rd_b0, exp_rd(1'b0, rdNumB));
        chk({tag, ":busy1"}, {31'b0, busy1}, eb);
        chk({tag, ":busy0"}, {31'b0, busy0}, eb);
        chk({tag, ":st1"}, {31'b0, st1 == CLEAR}, eb);
        chk({tag, ":st0"}, {31'b0, st0 == CLEAR}, eb);
    endtask

    // Reference update for one rising edge, using the inputs currently applied.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                m1[i] = '0;
                m0[i] = '0;
            end
            busy_left = 0;
        end else if (busy_left > 0) begin
            m1[D - busy_left] = '0;
            m0[D - busy_left] = '0;
            busy_left--;
        end else begin
            if (writeEn) begin
                m0[RegNum] = RegData;
                if (RegNum != '0) m1[RegNum] = RegData;
            end
            if (clearReq) busy_left = D;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < D; i++) begin
            rdNumA = AW'(i);
            rdNumB = AW'(D - 1 - i);
            #1;
            check_all(tag);
        end
    endtask

    initial begin
        int busy_cnt;
        for (int i = 0; i < D; i++) begin
            m1[i] = '0;
            m0[i] = '0;
        end
        busy_left = 0;
        rst = 1'b1; writeEn = 1'b0; clearReq = 1'b0;
        RegNum = '0; RegData = '0; rdNumA = '0; rdNumB = '0;
        @(negedge clk);
        tick();
        rst = 1'b0;

        // Reset then read
        rdNumA = 5'd7; rdNumB = 5'd31; #1;
        check_all("reset");

        // Write then read, with same-cycle bypass visible only on dut1
        writeEn = 1'b1; RegNum = 5'd5; RegData = 32'hDEADBEEF; rdNumA = 5'd5; rdNumB = 5'd4; #1;
        check_all("wr5_pre");
        chk("wr5_pre_lit_a1", rd_a1, 32'hDEADBEEF);
        chk("wr5_pre_lit_a0", rd_a0, 32'h0);
        tick();
        writeEn = 1'b0; #1;
        check_all("wr5_post");
        chk("wr5_post_lit_a0", rd_a0, 32'hDEADBEEF);

        // Bypass on entry 9
        writeEn = 1'b1; RegNum = 5'd9; RegData = 32'h12345678; rdNumA = 5'd9; rdNumB = 5'd9; #1;
        check_all("byp9_pre");
        tick();
        writeEn = 1'b0; #1;
        check_all("byp9_post");

        // Write to entry 0: discarded on dut1, stored on dut0
        writeEn = 1'b1; RegNum = 5'd0; RegData = 32'hFFFFFFFF; rdNumA = 5'd0; rdNumB = 5'd0; #1;
        check_all("zero_pre");
        tick();
        writeEn = 1'b0; #1;
        check_all("zero_post");
        chk("zero_post_lit_a1", rd_a1, 32'h0);

        // Random write/read traffic
        for (int n = 0; n < 300; n++) begin
            writeEn = 1'($urandom_range(0, 1));
            RegNum  = AW'($urandom_range(0, D - 1));
            RegData = $urandom;
            rdNumA  = ($urandom_range(0, 3) == 0) ? RegNum : AW'($urandom_range(0, D - 1));
            rdNumB  = AW'($urandom_range(0, D - 1));
            #1;
            check_all("rand");
            tick();
        end
        writeEn = 1'b0;

        // Fill 1..31 with index*0x11, then bulk clear
        for (int i = 1; i < D; i++) begin
            writeEn = 1'b1; RegNum = AW'(i); RegData = 32'(i * 32'h11);
            tick();
        end
        writeEn = 1'b0;
        read_all("filled");
        clearReq = 1'b1;
        tick();
        clearReq = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 40 && busy1; c++) begin
            busy_cnt++;
            writeEn  = (c == 5);
            RegNum   = 5'd3;
            RegData  = 32'hCAFEF00D;
            clearReq = (c == 20);
            rdNumA   = (c == 5) ? 5'd3 : AW'($urandom_range(0, D - 1));
            rdNumB   = AW'($urandom_range(0, D - 1));
            #1;
            check_all("clear");
            tick();
        end
        writeEn = 1'b0; clearReq = 1'b0;
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd32);
        read_all("cleared");

        // Reset mid-clear
        for (int i = 1; i < D; i++) begin
            writeEn = 1'b1; RegNum = AW'(i); RegData = $urandom;
            tick();
        end
        writeEn = 1'b0;
        clearReq = 1'b1;
        tick();
        clearReq = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check_all("preabort");
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        chk("abort_busy", {31'b0, busy1}, 32'd0);
        chk("abort_state", {31'b0, st1 == CLEAR}, 32'd0);
        read_all("abort");
        writeEn = 1'b1; RegNum = 5'd12; RegData = 32'hA5A5A5A5;
        tick();
        writeEn = 1'b0; rdNumA = 5'd12; rdNumB = 5'd12; #1;
        check_all("wr12");
        chk("wr12_lit_b1", rd_b1, 32'hA5A5A5A5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
